axi_arbiter_r: RTL and testbench

Round-robin arbiter for the AXI read path between four masters and one shared slave. It grants the AR channel to one master at a time and holds that grant through the whole R burst until the RLAST handshake. Only then is the grant released. It sits beside the write-channel arbiter in the interconnect, and its one-hot grants drive the AR/R muxes.

---
 rtl/axi_arb_pkg.sv | 20 ++
 rtl/axi_arbiter_r_if.sv | 33 +++
 rtl/axi_arbiter_r_rr_pick4.sv | 22 ++
 rtl/axi_arbiter_r.sv | 91 +++++++++
 tb/tb_axi_arbiter_r.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/axi_arb_pkg.sv
// Definitions shared by the AXI read and write arbiters: state encoding,
// master count, master-id type and the one-hot grant decode.
package axi_arb_pkg;

   localparam int NUM_MASTERS = 4;

   typedef logic [1:0] master_id_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_t;

   function automatic logic [NUM_MASTERS-1:0] id_to_onehot(input master_id_t id);
      id_to_onehot     = '0;
      id_to_onehot[id] = 1'b1;
   endfunction

endpackage

// File: rtl/axi_arbiter_r_if.sv
// Read-arbiter signal bundle: master requests, slave handshakes and arbiter status.
// The master modport is the interconnect side; the slave modport is the arbiter.
interface axi_arbiter_r_if #(
   parameter int BEAT_W = 9
);
   logic m0_ARVALID, m1_ARVALID, m2_ARVALID, m3_ARVALID;
   logic m0_RREADY, m1_RREADY, m2_RREADY, m3_RREADY;
   logic s_ARREADY;
   logic s_RVALID;
   logic s_RLAST;
   logic m0_rgrnt, m1_rgrnt, m2_rgrnt, m3_rgrnt;
   logic ar_phase;
   logic r_phase;
   logic [BEAT_W-1:0] beat_cnt;
   logic burst_done;

   modport master (
      output m0_ARVALID, m1_ARVALID, m2_ARVALID, m3_ARVALID,
      output m0_RREADY, m1_RREADY, m2_RREADY, m3_RREADY,
      output s_ARREADY, s_RVALID, s_RLAST,
      input  m0_rgrnt, m1_rgrnt, m2_rgrnt, m3_rgrnt,
      input  ar_phase, r_phase, beat_cnt, burst_done
   );

   modport slave (
      input  m0_ARVALID, m1_ARVALID, m2_ARVALID, m3_ARVALID,
      input  m0_RREADY, m1_RREADY, m2_RREADY, m3_RREADY,
      input  s_ARREADY, s_RVALID, s_RLAST,
      output m0_rgrnt, m1_rgrnt, m2_rgrnt, m3_rgrnt,
      output ar_phase, r_phase, beat_cnt, burst_done
   );

endinterface

// File: rtl/axi_arbiter_r_rr_pick4.sv
// Combinational 4-way round-robin pick: searches last+1, last+2, last+3, last
// and returns the first requester; the previous owner ranks last.
module rr_pick4
   import axi_arb_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] req,
   input  master_id_t             last,
   output master_id_t             winner,
   output logic                   valid
);

   always_comb begin
      // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
      winner = last;
      valid  = |req;
      // Walk from lowest to highest priority; the last hit written wins.
      for (int i = NUM_MASTERS; i >= 1; i--) begin
         if (req[last + master_id_t'(i)]) winner = last + master_id_t'(i);
      end
   end

endmodule

// File: rtl/axi_arbiter_r.sv
// Round-robin AXI read-path arbiter for four masters: grants AR to one master and
// holds the grant through its whole R burst until the RLAST handshake.
module axi_arbiter_r
   import axi_arb_pkg::*;
#(
   parameter int BEAT_W = 9
) (
   input logic            ACLK,
   input logic            ARESET,
   axi_arbiter_r_if.slave bus
);

   arb_state_t             state;
   master_id_t             owner;
   logic [BEAT_W-1:0]      beat_cnt;
   logic                   burst_done;

   logic [NUM_MASTERS-1:0] arvalid;
   logic [NUM_MASTERS-1:0] rready;
   logic [NUM_MASTERS-1:0] grant;
   master_id_t             winner;
   logic                   any_req;
   logic                   beat;

   assign arvalid = {bus.m3_ARVALID, bus.m2_ARVALID, bus.m1_ARVALID, bus.m0_ARVALID};
   assign rready  = {bus.m3_RREADY, bus.m2_RREADY, bus.m1_RREADY, bus.m0_RREADY};

   rr_pick4 u_pick (
      .req    (arvalid),
      .last   (owner),
      .winner (winner),
      .valid  (any_req)
   );

   assign beat = bus.s_RVALID && rready[owner];

   always_ff @(posedge ACLK) begin
      // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
      if (ARESET) begin
         // NOTE: every register here is a small control flop, so all of them are reset; there is no storage array to leave unreset.
         state      <= IDLE;
         owner      <= '0;
         beat_cnt   <= '0;
         burst_done <= 1'b0;
      end else begin
         burst_done <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner <= winner;
                  state <= ADDR;
               end
            end
            ADDR: begin
               // A dropped ARVALID just stalls here; other requesters wait.
               if (arvalid[owner] && bus.s_ARREADY) begin
                  state    <= DATA;
                  beat_cnt <= '0;
               end
            end
            DATA: begin
               if (beat) begin
                  if (beat_cnt != '1) beat_cnt <= beat_cnt + BEAT_W'(1);
                  if (bus.s_RLAST) begin
                     burst_done <= 1'b1;
                     if (any_req) begin
                        owner <= winner;
                        state <= ADDR;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode registers only; the owner stays parked while idle.
   assign grant          = id_to_onehot(owner);
   assign bus.m0_rgrnt   = grant[0];
   assign bus.m1_rgrnt   = grant[1];
   assign bus.m2_rgrnt   = grant[2];
   assign bus.m3_rgrnt   = grant[3];
   assign bus.ar_phase   = (state == ADDR);
   assign bus.r_phase    = (state == DATA);
   assign bus.beat_cnt   = beat_cnt;
   assign bus.burst_done = burst_done;

endmodule

// File: tb/tb_axi_arbiter_r.sv
// Scoreboard bench for axi_arbiter_r: two instances (BEAT_W 9 and 2) share one
// stimulus stream and are compared each cycle against a behavioural model.
module tb_axi_arbiter_r;

   logic       ACLK = 1'b0;
   logic       areset = 1'b1;
   logic [3:0] arv = '0;
   logic [3:0] rr = '0;
   logic       s_arready = 1'b0;
   logic       s_rvalid = 1'b0;
   logic       s_rlast = 1'b0;

   always #5 ACLK = ~ACLK;

   axi_arbiter_r_if #(.BEAT_W(9)) bus9 ();
   axi_arbiter_r_if #(.BEAT_W(2)) bus2 ();

   assign bus9.m0_ARVALID = arv[0];  assign bus2.m0_ARVALID = arv[0];
   assign bus9.m1_ARVALID = arv[1];  assign bus2.m1_ARVALID = arv[1];
   assign bus9.m2_ARVALID = arv[2];  assign bus2.m2_ARVALID = arv[2];
   assign bus9.m3_ARVALID = arv[3];  assign bus2.m3_ARVALID = arv[3];
   assign bus9.m0_RREADY  = rr[0];   assign bus2.m0_RREADY  = rr[0];
   assign bus9.m1_RREADY  = rr[1];   assign bus2.m1_RREADY  = rr[1];
   assign bus9.m2_RREADY  = rr[2];   assign bus2.m2_RREADY  = rr[2];
   assign bus9.m3_RREADY  = rr[3];   assign bus2.m3_RREADY  = rr[3];
   assign bus9.s_ARREADY  = s_arready; assign bus2.s_ARREADY = s_arready;
   assign bus9.s_RVALID   = s_rvalid;  assign bus2.s_RVALID  = s_rvalid;
   assign bus9.s_RLAST    = s_rlast;   assign bus2.s_RLAST   = s_rlast;

   axi_arbiter_r #(.BEAT_W(9)) dut9 (.ACLK(ACLK), .ARESET(areset), .bus(bus9.slave));
   axi_arbiter_r #(.BEAT_W(2)) dut2 (.ACLK(ACLK), .ARESET(areset), .bus(bus2.slave));

   typedef struct {
      logic [3:0] grant;
      logic       ar_phase;
      logic       r_phase;
      int         bc9;
      int         bc2;
      logic       done;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Reference model: who owns the slave, whether it is waiting for AR or
   // streaming R, and an unbounded count of accepted beats.
   int m_owner = 0;
   bit m_wait_ar = 0;
   bit m_streaming = 0;
   int m_beats = 0;
   bit m_done = 0;

   function automatic int next_owner(input logic [3:0] req, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (req[(last + k) % 4]) return (last + k) % 4;
      end
      return last;
   endfunction

   function automatic int clip(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic model_step();
      m_done = 0;
      if (areset) begin
         m_owner = 0; m_wait_ar = 0; m_streaming = 0; m_beats = 0;
      end else if (m_streaming) begin
         if (s_rvalid && rr[m_owner]) begin
            m_beats++;
            if (s_rlast) begin
               m_done = 1;
               m_streaming = 0;
               if (arv != 0) begin
                  m_owner = next_owner(arv, m_owner);
                  m_wait_ar = 1;
               end
            end
         end
      end else if (m_wait_ar) begin
         if (arv[m_owner] && s_arready) begin
            m_wait_ar = 0; m_streaming = 1; m_beats = 0;
         end
      end else if (arv != 0) begin
         m_owner = next_owner(arv, m_owner);
         m_wait_ar = 1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
   endtask

   // Apply one cycle of inputs at the falling edge and queue the expected outputs.
   task automatic drive(input logic [3:0] a, input logic [3:0] r, input logic ar,
                        input logic rv, input logic rl, input logic rst);
      exp_t e;
      @(negedge ACLK);
      arv = a; rr = r; s_arready = ar; s_rvalid = rv; s_rlast = rl; areset = rst;
      model_step();
      e.grant    = 4'(1 << m_owner);
      e.ar_phase = m_wait_ar;
      e.r_phase  = m_streaming;
      e.bc9      = clip(m_beats, 511);
      e.bc2      = clip(m_beats, 3);
      e.done     = m_done;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic reset_cycle();
      drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // Monitor: compare queued expectations one cycle at a time, 1 ns after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge ACLK);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cyc++;
            check("grant9",     {28'd0, bus9.m3_rgrnt, bus9.m2_rgrnt, bus9.m1_rgrnt, bus9.m0_rgrnt}, {28'd0, e.grant});
            check("ar_phase9",  {31'd0, bus9.ar_phase},   {31'd0, e.ar_phase});
            check("r_phase9",   {31'd0, bus9.r_phase},    {31'd0, e.r_phase});
            check("beat_cnt9",  {23'd0, bus9.beat_cnt},   e.bc9);
            check("burst_done9",{31'd0, bus9.burst_done}, {31'd0, e.done});
            check("grant2",     {28'd0, bus2.m3_rgrnt, bus2.m2_rgrnt, bus2.m1_rgrnt, bus2.m0_rgrnt}, {28'd0, e.grant});
            check("beat_cnt2",  {30'd0, bus2.beat_cnt},   e.bc2);
            check("burst_done2",{31'd0, bus2.burst_done}, {31'd0, e.done});
         end
      end
   end

   initial begin
      // Reset, then a single 4-beat burst from m2 with ARREADY on cycle 3.
      reset_cycle();
      drive(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive(4'b0000, 4'b0100, 1'b0, 1'b1, 1'(i == 3), 1'b0);
      idle(3);

      // All four requesting with single-beat bursts: owners rotate 1,2,3,0,1.
      reset_cycle();
      repeat (12) drive(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(2);

      // RREADY stall for 3 cycles, then 2 beats.
      reset_cycle();
      repeat (2) drive(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(4'b0000, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(2);

      // m1 requests while m0 is mid-burst; it takes over right after RLAST.
      reset_cycle();
      repeat (2) drive(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) drive(4'b0010, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(4'b0010, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(4'b0000, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(2);

      // Reset in the middle of a burst after 3 beats.
      reset_cycle();
      repeat (2) drive(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) drive(4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
      reset_cycle();
      idle(2);

      // 6-beat burst: the 2-bit counter saturates at 3, done still pulses.
      repeat (2) drive(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) drive(4'b0000, 4'b0001, 1'b0, 1'b1, 1'(i == 5), 1'b0);
      idle(2);

      // Random traffic, including dropped ARVALIDs and occasional resets.
      repeat (3000) begin
         drive(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 99) == 0));
      end
      idle(2);

      @(posedge ACLK);
      #2;
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
